// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles 5-byte command frames (header, cmd, addr, data,
// checksum) from the UART receiver's byte stream. It issues one-cycle
// register write/read requests and flags bad frames and abandoned partial
// frames.
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_MAX = 52080,
  parameter logic [7:0]  HEADER      = 8'hAA,
  parameter logic [7:0]  CMD_WR      = 8'h01,
  parameter logic [7:0]  CMD_RD      = 8'h02
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_ready,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_rd_req,
  output logic [7:0] o_rd_addr,
  output logic       o_frame_err,
  output logic       o_timeout,
  output logic       o_busy,
  output logic [7:0] o_frame_cnt
);

  // Counter only needs to reach TIMEOUT_MAX-1; keep at least one bit.
  localparam int TW = ($clog2(TIMEOUT_MAX) > 0) ? $clog2(TIMEOUT_MAX) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_CHK
  } state_t;

  state_t        r_state;
  logic          r_rx_ready_d;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_cmd;
  logic [7:0]    r_addr;
  logic [7:0]    r_data;
  logic          r_wr_en;
  logic [7:0]    r_wr_addr;
  logic [7:0]    r_wr_data;
  logic          r_rd_req;
  logic [7:0]    r_rd_addr;
  logic          r_frame_err;
  logic          r_timeout;
  logic          r_busy;
  logic [7:0]    r_frame_cnt;

  logic w_byte_stb;
  logic w_chk_ok;

  // A byte event is the rising edge of the receiver's ready level.
  assign w_byte_stb = i_rx_ready & ~r_rx_ready_d;
  assign w_chk_ok   = (i_rx_data == (r_cmd ^ r_addr ^ r_data));

  // Ready-level delay; resets high so a level held through reset is not an event.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_ready_d <= 1'b1;
    end else begin
      r_rx_ready_d <= i_rx_ready;
    end
  end

  // Frame FSM with inter-byte timeout; a byte on the terminal-count cycle wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_to_cnt    <= '0;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= '0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_wr_en     <= 1'b0;
      r_rd_req    <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
      if (w_byte_stb) begin
        r_to_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (i_rx_data == HEADER) begin
              r_state <= S_CMD;
              r_busy  <= 1'b1;
            end
          end
          S_CMD: begin
            r_cmd   <= i_rx_data;
            r_state <= S_ADDR;
          end
          S_ADDR: begin
            r_addr  <= i_rx_data;
            r_state <= S_DATA;
          end
          S_DATA: begin
            r_data  <= i_rx_data;
            r_state <= S_CHK;
          end
          S_CHK: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (w_chk_ok && (r_cmd == CMD_WR)) begin
              r_wr_en     <= 1'b1;
              r_wr_addr   <= r_addr;
              r_wr_data   <= r_data;
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end else if (w_chk_ok && (r_cmd == CMD_RD)) begin
              r_rd_req    <= 1'b1;
              r_rd_addr   <= r_addr;
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end else if (r_state == S_IDLE) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == TO_LAST) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_timeout <= 1'b1;
        r_to_cnt  <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
    end
  end

  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_rd_req    = r_rd_req;
  assign o_rd_addr   = r_rd_addr;
  assign o_frame_err = r_frame_err;
  assign o_timeout   = r_timeout;
  assign o_busy      = r_busy;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed and randomized frames against a frame-level
// reference model; every cycle's outputs are compared with the model.
module tb_uart_cmd_ctrl;

  localparam int         TM  = 40;
  localparam logic [7:0] HDR = 8'hAA;
  localparam logic [7:0] WR  = 8'h01;
  localparam logic [7:0] RD  = 8'h02;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxData;
  logic       rxReady;
  logic       wrEn, rdReq, frameErr, timeoutP, busy;
  logic [7:0] wrAddr, wrData, rdAddr, frameCnt;

  uart_cmd_ctrl #(.TIMEOUT_MAX(TM)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rxData),
    .i_rx_ready (rxReady),
    .o_wr_en    (wrEn),
    .o_wr_addr  (wrAddr),
    .o_wr_data  (wrData),
    .o_rd_req   (rdReq),
    .o_rd_addr  (rdAddr),
    .o_frame_err(frameErr),
    .o_timeout  (timeoutP),
    .o_busy     (busy),
    .o_frame_cnt(frameCnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: bytes collected so far in the current frame, idle cycles since last byte.
  int         mLen  = 0;
  int         mIdle = 0;
  logic       mPrev = 1'b1;
  logic [7:0] mBuf [5];
  logic       eWr, eRd, eErr, eTo, eBusy;
  logic [7:0] eWrAddr, eWrData, eRdAddr, eCnt;
  int         wrSeen = 0, rdSeen = 0, errSeen = 0, toSeen = 0;

  task automatic finishFrame();
    logic good;
    good = (mBuf[4] == (mBuf[1] ^ mBuf[2] ^ mBuf[3]));
    if (good && mBuf[1] == WR) begin
      eWr = 1'b1; eWrAddr = mBuf[2]; eWrData = mBuf[3]; eCnt = eCnt + 8'd1;
    end else if (good && mBuf[1] == RD) begin
      eRd = 1'b1; eRdAddr = mBuf[2]; eCnt = eCnt + 8'd1;
    end else begin
      eErr = 1'b1;
    end
  endtask

  task automatic modelStep();
    logic stb;
    eWr = 1'b0; eRd = 1'b0; eErr = 1'b0; eTo = 1'b0;
    if (rst) begin
      mLen = 0; mIdle = 0; mPrev = 1'b1;
      eWrAddr = 8'h00; eWrData = 8'h00; eRdAddr = 8'h00; eCnt = 8'h00;
    end else begin
      stb   = rxReady && !mPrev;
      mPrev = rxReady;
      if (stb) begin
        mIdle = 0;
        if (mLen == 0) begin
          if (rxData == HDR) mLen = 1;
        end else begin
          mBuf[mLen] = rxData;
          mLen++;
          if (mLen == 5) begin
            finishFrame();
            mLen = 0;
          end
        end
      end else if (mLen > 0) begin
        mIdle++;
        if (mIdle == TM) begin
          eTo = 1'b1; mLen = 0; mIdle = 0;
        end
      end
    end
    eBusy = (mLen > 0);
  endtask

  task automatic checkOutput();
    checks++;
    assert ({wrEn, rdReq, frameErr, timeoutP, busy} === {eWr, eRd, eErr, eTo, eBusy})
    else begin
      failures++;
      $error("[TB] FAIL strobes(wr,rd,err,to,busy) t=%0t actual=%b expected=%b", $time,
             {wrEn, rdReq, frameErr, timeoutP, busy}, {eWr, eRd, eErr, eTo, eBusy});
    end
    checks++;
    assert ({wrAddr, wrData, rdAddr} === {eWrAddr, eWrData, eRdAddr})
    else begin
      failures++;
      $error("[TB] FAIL addr_data t=%0t actual=%h expected=%h", $time,
             {wrAddr, wrData, rdAddr}, {eWrAddr, eWrData, eRdAddr});
    end
    checks++;
    assert (frameCnt === eCnt)
    else begin
      failures++;
      $error("[TB] FAIL frame_cnt t=%0t actual=%0d expected=%0d", $time, frameCnt, eCnt);
    end
    if (wrEn === 1'b1) wrSeen++;
    if (rdReq === 1'b1) rdSeen++;
    if (frameErr === 1'b1) errSeen++;
    if (timeoutP === 1'b1) toSeen++;
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
  task automatic applyStimulus(input logic r, input logic rdy, input logic [7:0] d);
    rst = r; rxReady = rdy; rxData = d;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic sendByte(input logic [7:0] b, input int hold, input int gap);
    repeat (hold) applyStimulus(1'b0, 1'b1, b);
    repeat (gap) applyStimulus(1'b0, 1'b0, b);
  endtask

  task automatic sendFrame(input logic [7:0] c, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] k);
    sendByte(HDR, $urandom_range(1, 2), $urandom_range(1, 3));
    sendByte(c,   $urandom_range(1, 2), $urandom_range(1, 3));
    sendByte(a,   $urandom_range(1, 2), $urandom_range(1, 3));
    sendByte(d,   $urandom_range(1, 2), $urandom_range(1, 3));
    sendByte(k,   $urandom_range(1, 2), $urandom_range(1, 3));
  endtask

  task automatic directCheck(input string tag, input int actual, input int expected);
    checks++;
    assert (actual === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  int         w0, r0, e0, t0;
  logic [7:0] ra, rd, rc, rk;

  initial begin
    rst = 1'b1; rxReady = 1'b0; rxData = 8'h00;
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    directCheck("reset_frame_cnt", int'(frameCnt), 0);

    // Basic write, read, bad checksum, unknown command
    w0 = wrSeen;
    sendFrame(8'h01, 8'h10, 8'h5A, 8'h4B);
    directCheck("write_pulses", wrSeen - w0, 1);
    directCheck("write_addr", int'(wrAddr), 8'h10);
    directCheck("write_data", int'(wrData), 8'h5A);
    directCheck("write_cnt", int'(frameCnt), 1);
    r0 = rdSeen; w0 = wrSeen;
    sendFrame(8'h02, 8'h33, 8'h00, 8'h31);
    directCheck("read_pulses", rdSeen - r0, 1);
    directCheck("read_no_write", wrSeen - w0, 0);
    directCheck("read_addr", int'(rdAddr), 8'h33);
    e0 = errSeen;
    sendFrame(8'h01, 8'h10, 8'h5A, 8'h4C);
    sendFrame(8'h07, 8'h00, 8'h00, 8'h07);
    directCheck("bad_frames_err", errSeen - e0, 2);
    directCheck("bad_frames_cnt", int'(frameCnt), 2);

    // Garbage before header, then a write to 01
    w0 = wrSeen;
    sendByte(8'h55, 2, 2);
    sendByte(8'h00, 2, 2);
    sendFrame(8'h01, 8'h01, 8'h01, 8'h01);
    directCheck("resync_write", wrSeen - w0, 1);
    directCheck("resync_addr", int'(wrAddr), 8'h01);

    // Partial frame abandoned after TM idle cycles, then a normal frame
    t0 = toSeen; w0 = wrSeen;
    sendByte(HDR, 2, 2);
    sendByte(8'h01, 1, TM + 4);
    directCheck("timeout_pulses", toSeen - t0, 1);
    sendFrame(8'h01, 8'h10, 8'h5A, 8'h4B);
    directCheck("after_timeout_write", wrSeen - w0, 1);

    // Next byte lands exactly on the terminal-count cycle
    t0 = toSeen; w0 = wrSeen;
    sendByte(HDR, 2, 2);
    sendByte(8'h01, 2, TM - 2);
    sendByte(8'h20, 2, TM - 2);
    sendByte(8'h30, 2, 2);
    sendByte(8'h01 ^ 8'h20 ^ 8'h30, 2, 2);
    directCheck("terminal_no_timeout", toSeen - t0, 0);
    directCheck("terminal_write", wrSeen - w0, 1);

    // Reset mid-frame with ready held high through release
    sendByte(HDR, 2, 2);
    sendByte(8'h01, 2, 2);
    sendByte(8'h10, 2, 2);
    repeat (2) applyStimulus(1'b1, 1'b1, 8'hAA);
    repeat (4) applyStimulus(1'b0, 1'b1, 8'hAA);
    directCheck("reset_busy", int'(busy), 0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    w0 = wrSeen;
    sendFrame(8'h01, 8'h44, 8'h55, 8'h01 ^ 8'h44 ^ 8'h55);
    directCheck("post_reset_write", wrSeen - w0, 1);

    // 256 good random frames from reset: counter wraps to 0
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++) begin
      rc = ($urandom_range(0, 1) == 0) ? WR : RD;
      ra = 8'($urandom);
      rd = 8'($urandom);
      sendFrame(rc, ra, rd, rc ^ ra ^ rd);
    end
    directCheck("wrap_cnt", int'(frameCnt), 0);

    // Random mix of garbage, corrupted and unknown-command frames
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) sendByte(8'($urandom_range(0, 8'hA9)), 1, 2);
      rc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (($urandom_range(0, 1) == 0) ? WR : RD);
      ra = 8'($urandom);
      rd = 8'($urandom);
      rk = rc ^ ra ^ rd;
      if ($urandom_range(0, 3) == 0) rk = rk ^ 8'($urandom_range(1, 255));
      sendFrame(rc, ra, rd, rk);
    end
    repeat (5) applyStimulus(1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
